// File: rtl/hs_module_monitor.sv
// Per-channel ap_ctrl_hs / ap_ctrl_chain handshake monitor with saturating
// statistics counters, sticky freeze, synchronous clear and a registered read port.
module hs_module_monitor #(
  parameter int N_CH    = 21,
  parameter int CNT_W   = 32,
  parameter bit CONT_EN = 1'b1,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            finish,
  input  logic            clear,
  input  logic [N_CH-1:0] ap_start,
  input  logic [N_CH-1:0] ap_ready,
  input  logic [N_CH-1:0] ap_done,
  input  logic [N_CH-1:0] ap_continue,
  input  logic            rd_en,
  input  logic [CH_W-1:0] rd_ch,
  input  logic [2:0]      rd_sel,
  output logic            rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic            rd_err,
  output logic            frozen,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] proto_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DWAIT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Read-visible fields per channel, indexed by rd_sel (7 = FSM state).
  logic [CNT_W-1:0] fld [N_CH][8];

  always_ff @(posedge clock) begin
    if (reset) frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           st;
    logic             start_q, ready_seen, perr;
    logic [CNT_W-1:0] start_cnt, done_cnt, ready_cnt, busy_cyc;
    logic [CNT_W-1:0] stall_cyc, last_lat, max_lat, lat_ctr;
    logic             cont_ok;
    logic [CNT_W-1:0] lat_next;

    assign cont_ok  = CONT_EN ? ap_continue[c] : 1'b1;
    // lat_ctr counts cycles after the start cycle, so the inclusive latency is one more.
    assign lat_next = sat_inc(lat_ctr);

    always_ff @(posedge clock) begin
      if (reset) begin
        st         <= IDLE;
        start_q    <= 1'b0;
        ready_seen <= 1'b0;
        perr       <= 1'b0;
        start_cnt  <= '0;
        done_cnt   <= '0;
        ready_cnt  <= '0;
        busy_cyc   <= '0;
        stall_cyc  <= '0;
        last_lat   <= '0;
        max_lat    <= '0;
        lat_ctr    <= '0;
      end else begin
        if (!frozen) begin
          start_q <= ap_start[c];
          if (ap_ready[c]) ready_cnt <= sat_inc(ready_cnt);
          case (st)
            IDLE: begin
              if (ap_done[c]) begin
                perr <= 1'b1;
              end else if (ap_start[c]) begin
                st         <= RUN;
                start_cnt  <= sat_inc(start_cnt);
                lat_ctr    <= CNT_ONE;
                ready_seen <= ap_ready[c];
              end
            end
            RUN: begin
              busy_cyc <= sat_inc(busy_cyc);
              lat_ctr  <= lat_next;
              if (ap_ready[c]) ready_seen <= 1'b1;
              if (start_q && !ap_start[c] && !(ready_seen || ap_ready[c])) perr <= 1'b1;
              if (ap_done[c]) begin
                done_cnt <= sat_inc(done_cnt);
                last_lat <= lat_next;
                if (lat_next > max_lat) max_lat <= lat_next;
                // A done cycle without continue is already a back-pressure cycle.
                if (cont_ok) st <= IDLE;
                else begin
                  st        <= DWAIT;
                  stall_cyc <= sat_inc(stall_cyc);
                end
              end
            end
            DWAIT: begin
              busy_cyc <= sat_inc(busy_cyc);
              if (cont_ok) st <= IDLE;
              else stall_cyc <= sat_inc(stall_cyc);
            end
            default: st <= IDLE;
          endcase
        end
        if (clear) begin
          perr      <= 1'b0;
          start_cnt <= '0;
          done_cnt  <= '0;
          ready_cnt <= '0;
          busy_cyc  <= '0;
          stall_cyc <= '0;
          last_lat  <= '0;
          max_lat   <= '0;
          lat_ctr   <= CNT_ONE;
        end
      end
    end

    assign busy[c]      = (st != IDLE);
    assign proto_err[c] = perr;
    assign fld[c][0]    = start_cnt;
    assign fld[c][1]    = done_cnt;
    assign fld[c][2]    = ready_cnt;
    assign fld[c][3]    = busy_cyc;
    assign fld[c][4]    = stall_cyc;
    assign fld[c][5]    = last_lat;
    assign fld[c][6]    = max_lat;
    assign fld[c][7]    = CNT_W'(st);
  end

  logic [CNT_W-1:0] sel_data;
  logic             oob;

  always_comb begin
    sel_data = '0;
    oob      = (int'(rd_ch) >= N_CH);
    for (int i = 0; i < N_CH; i++) begin
      if (int'(rd_ch) == i) sel_data = fld[i][rd_sel];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & oob;
      if (rd_en) rd_data <= oob ? '0 : sel_data;
    end
  end

endmodule

// File: tb/tb_hs_module_monitor.sv
// Bench for hs_module_monitor: directed tables, hand sequences and randomized
// traffic checked against a timestamp-based transaction model.
module tb_hs_module_monitor;

  localparam int NA = 21;
  localparam int WA = 32;
  localparam int NB = 5;
  localparam int WB = 4;
  localparam longint MAXA = (longint'(1) << WA) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic          a_finish, a_clear, a_rd_en;
  logic [NA-1:0] a_start, a_ready, a_done, a_cont;
  logic [4:0]    a_rd_ch;
  logic [2:0]    a_rd_sel;
  logic          a_rd_valid, a_rd_err, a_frozen;
  logic [WA-1:0] a_rd_data;
  logic [NA-1:0] a_busy, a_perr;

  logic          b_finish, b_clear, b_rd_en;
  logic [NB-1:0] b_start, b_ready, b_done, b_cont;
  logic [2:0]    b_rd_ch;
  logic [2:0]    b_rd_sel;
  logic          b_rd_valid, b_rd_err, b_frozen;
  logic [WB-1:0] b_rd_data;
  logic [NB-1:0] b_busy, b_perr;

  hs_module_monitor #(.N_CH(NA), .CNT_W(WA), .CONT_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .finish(a_finish), .clear(a_clear),
    .ap_start(a_start), .ap_ready(a_ready), .ap_done(a_done), .ap_continue(a_cont),
    .rd_en(a_rd_en), .rd_ch(a_rd_ch), .rd_sel(a_rd_sel),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err),
    .frozen(a_frozen), .busy(a_busy), .proto_err(a_perr)
  );

  hs_module_monitor #(.N_CH(NB), .CNT_W(WB), .CONT_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .finish(b_finish), .clear(b_clear),
    .ap_start(b_start), .ap_ready(b_ready), .ap_done(b_done), .ap_continue(b_cont),
    .rd_en(b_rd_en), .rd_ch(b_rd_ch), .rd_sel(b_rd_sel),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err),
    .frozen(b_frozen), .busy(b_busy), .proto_err(b_perr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a channel is either idle, in flight, or waiting for continue.
  // Latency is the distance between timestamps, not a running counter.
  bit     m_act [NA], m_wait [NA], m_perr [NA], m_sprev [NA], m_rseen [NA];
  longint m_t0 [NA];
  longint m_f [NA][7];
  longint cyc = 0;
  logic [32:0] exp_q[$];

  function automatic longint sat(input longint v);
    return (v > MAXA) ? MAXA : v;
  endfunction

  task automatic bump(input int c, input int k);
    m_f[c][k] = sat(m_f[c][k] + 1);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NA; c++) begin
      m_act[c] = 0; m_wait[c] = 0; m_perr[c] = 0; m_sprev[c] = 0; m_rseen[c] = 0;
      m_t0[c] = 0;
      for (int k = 0; k < 7; k++) m_f[c][k] = 0;
    end
  endtask

  task automatic model_step();
    longint lat;
    for (int c = 0; c < NA; c++) begin
      if (a_ready[c]) bump(c, 2);
      if (!m_act[c]) begin
        if (a_done[c]) m_perr[c] = 1;
        else if (a_start[c]) begin
          m_act[c] = 1; m_wait[c] = 0; m_t0[c] = cyc; m_rseen[c] = a_ready[c];
          bump(c, 0);
        end
      end else if (!m_wait[c]) begin
        bump(c, 3);
        if (m_sprev[c] && !a_start[c] && !m_rseen[c] && !a_ready[c]) m_perr[c] = 1;
        if (a_ready[c]) m_rseen[c] = 1;
        if (a_done[c]) begin
          lat = sat(cyc - m_t0[c] + 1);
          m_f[c][5] = lat;
          if (lat > m_f[c][6]) m_f[c][6] = lat;
          bump(c, 1);
          if (a_cont[c]) m_act[c] = 0;
          else begin m_wait[c] = 1; bump(c, 4); end
        end
      end else begin
        bump(c, 3);
        if (a_cont[c]) begin m_act[c] = 0; m_wait[c] = 0; end
        else bump(c, 4);
      end
      m_sprev[c] = a_start[c];
      if (a_clear) begin
        for (int k = 0; k < 7; k++) m_f[c][k] = 0;
        m_perr[c] = 0;
        m_t0[c] = cyc;
      end
    end
    cyc++;
  endtask

  function automatic logic [32:0] model_read(input int ch, input int sel);
    if (ch >= NA) return {1'b1, 32'd0};
    if (sel == 7) return {1'b0, 32'(m_act[ch] ? (m_wait[ch] ? 2 : 1) : 0)};
    return {1'b0, 32'(m_f[ch][sel])};
  endfunction

  function automatic logic [NA-1:0] model_vec(input bit want_err);
    logic [NA-1:0] v;
    for (int c = 0; c < NA; c++) v[c] = want_err ? m_perr[c] : m_act[c];
    return v;
  endfunction

  // One clock of dut_a with model update and scoreboard comparison.
  task automatic step_a();
    bit was_rd;
    was_rd = a_rd_en && !reset;
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      if (a_rd_en) exp_q.push_back(model_read(int'(a_rd_ch), int'(a_rd_sel)));
      model_step();
    end
    @(posedge clock); #1;
    check("a_rd_valid", a_rd_valid, was_rd);
    if (was_rd && exp_q.size() > 0) check("a_read_model", {a_rd_err, a_rd_data}, exp_q.pop_front());
    check("a_busy_model", a_busy, model_vec(0));
    check("a_perr_model", a_perr, model_vec(1));
  endtask

  task automatic read_a(input logic [4:0] ch, input logic [2:0] sel, input logic [31:0] exp, input string name);
    a_rd_en = 1'b1; a_rd_ch = ch; a_rd_sel = sel;
    step_a();
    check(name, {a_rd_valid, a_rd_err, a_rd_data}, {2'b10, exp});
    a_rd_en = 1'b0;
  endtask

  task automatic step_b();
    @(posedge clock); #1;
  endtask

  task automatic read_b(input logic [2:0] ch, input logic [2:0] sel, input logic [3:0] exp, input string name);
    b_rd_en = 1'b1; b_rd_ch = ch; b_rd_sel = sel;
    step_b();
    check(name, {b_rd_valid, b_rd_err, b_rd_data}, {2'b10, exp});
    b_rd_en = 1'b0;
  endtask

  typedef struct {logic s; logic r; logic d; logic k; logic exp_busy;} vec_t;
  typedef struct {logic [2:0] sel; logic [31:0] exp;} rd_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    tbl [9];
    rd_vec_t rtbl [8];

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i < 7; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rtbl[0] = '{3'd0, 32'd1}; rtbl[1] = '{3'd1, 32'd1}; rtbl[2] = '{3'd2, 32'd1};
    rtbl[3] = '{3'd3, 32'd7}; rtbl[4] = '{3'd4, 32'd0}; rtbl[5] = '{3'd5, 32'd8};
    rtbl[6] = '{3'd6, 32'd8}; rtbl[7] = '{3'd7, 32'd0};

    reset = 1'b1;
    a_finish = 0; a_clear = 0; a_rd_en = 0; a_rd_ch = '0; a_rd_sel = '0;
    a_start = '0; a_ready = '0; a_done = '0; a_cont = '0;
    b_finish = 0; b_clear = 0; b_rd_en = 0; b_rd_ch = '0; b_rd_sel = '0;
    b_start = '0; b_ready = '0; b_done = '0; b_cont = '0;
    model_reset();

    // Clock/reset
    step_a(); step_a();
    reset = 1'b0;
    step_a();
    check("reset_busy", a_busy, 0);
    check("reset_perr", a_perr, 0);
    check("reset_frozen", a_frozen, 0);
    check("reset_rd", {a_rd_valid, a_rd_err, a_rd_data}, 0);
    check("reset_b", {b_busy, b_perr, b_frozen, b_rd_valid, b_rd_err, b_rd_data}, 0);

    // ch0 single transaction, latency 8
    for (int i = 0; i < 9; i++) begin
      a_start[0] = tbl[i].s; a_ready[0] = tbl[i].r; a_done[0] = tbl[i].d; a_cont[0] = tbl[i].k;
      step_a();
      check("ch0_busy", a_busy[0], tbl[i].exp_busy);
    end
    for (int i = 0; i < 8; i++) read_a(5'd0, rtbl[i].sel, rtbl[i].exp, "ch0_field");

    // ch3 done with continue held low for three cycles
    a_start[3] = 1; a_ready[3] = 1; step_a();
    a_start[3] = 0; a_ready[3] = 0; step_a(); step_a();
    a_done[3] = 1; a_cont[3] = 0; step_a();
    check("ch3_busy_dwait", a_busy[3], 1);
    a_done[3] = 0; step_a();
    read_a(5'd3, 3'd7, 32'd2, "ch3_state_dwait");
    a_cont[3] = 1; step_a();
    check("ch3_busy_idle", a_busy[3], 0);
    a_cont[3] = 0;
    read_a(5'd3, 3'd4, 32'd3, "ch3_stall");
    read_a(5'd3, 3'd1, 32'd1, "ch3_done_once");
    read_a(5'd3, 3'd5, 32'd4, "ch3_last_lat");
    read_a(5'd3, 3'd3, 32'd6, "ch3_busy_cyc");

    // done on idle ch1
    a_done[1] = 1; step_a(); a_done[1] = 0;
    check("ch1_perr_set", a_perr[1], 1);
    read_a(5'd1, 3'd1, 32'd0, "ch1_done_cnt");
    a_clear = 1; step_a(); a_clear = 0;
    check("ch1_perr_clr", a_perr[1], 0);
    read_a(5'd0, 3'd0, 32'd0, "ch0_cleared");

    // ch4 start drops before ready
    a_start[4] = 1; step_a();
    a_start[4] = 0; step_a();
    check("ch4_perr", {a_perr[4], a_busy[4]}, 2'b11);
    a_done[4] = 1; a_cont[4] = 1; step_a();
    a_done[4] = 0; a_cont[4] = 0;
    check("ch4_idle", a_busy[4], 0);
    read_a(5'd4, 3'd1, 32'd1, "ch4_done_cnt");

    // ch5 back-to-back with start held
    a_start[5] = 1; a_ready[5] = 1; step_a();
    a_ready[5] = 0; a_done[5] = 1; a_cont[5] = 1; step_a();
    check("ch5_idle_gap", a_busy[5], 0);
    a_done[5] = 0; a_ready[5] = 1; step_a();
    check("ch5_restart", a_busy[5], 1);
    a_start[5] = 0; a_ready[5] = 0; a_done[5] = 1; step_a();
    a_done[5] = 0; a_cont[5] = 0;
    read_a(5'd5, 3'd0, 32'd2, "ch5_start_cnt");
    read_a(5'd5, 3'd5, 32'd2, "ch5_last_lat");
    check("ch5_no_perr", a_perr[5], 0);

    // randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < NA; c++) begin
        a_start[c] = ($urandom_range(0, 9) < 4);
        a_ready[c] = ($urandom_range(0, 9) < 4);
        a_done[c]  = m_act[c] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
        a_cont[c]  = $urandom_range(0, 1) == 1;
      end
      a_clear = ($urandom_range(0, 99) == 0);
      step_a();
    end
    a_start = '0; a_ready = '0; a_done = '0; a_cont = '0; a_clear = 0;
    for (int c = 0; c < NA; c++) begin
      for (int s = 0; s < 8; s++) begin
        a_rd_en = 1; a_rd_ch = 5'(c); a_rd_sel = 3'(s);
        step_a();
      end
    end
    a_rd_ch = 5'd21; a_rd_sel = 3'd0; step_a();
    a_rd_ch = 5'd31; a_rd_sel = 3'd3; step_a();
    a_rd_en = 0; step_a();

    // reset while ch0 is in flight
    reset = 1; step_a(); reset = 0; step_a();
    a_start[0] = 1; a_ready[0] = 1; step_a();
    a_start[0] = 0; a_ready[0] = 0;
    for (int i = 0; i < 4; i++) step_a();
    reset = 1; step_a(); reset = 0;
    check("rst_mid_busy", a_busy, 0);
    for (int s = 0; s < 8; s++) read_a(5'd0, 3'(s), 32'd0, "rst_mid_field");
    a_start[0] = 1; a_ready[0] = 1; step_a();
    a_start[0] = 0; a_ready[0] = 0; step_a();
    a_done[0] = 1; a_cont[0] = 1; step_a();
    a_done[0] = 0; a_cont[0] = 0;
    read_a(5'd0, 3'd5, 32'd3, "rst_mid_relat");

    // dut_b: no continue handshake, 4-bit counters
    b_start[3] = 1; b_ready[3] = 1; step_b();
    b_start[3] = 0; b_ready[3] = 0; step_b(); step_b();
    b_done[3] = 1; step_b();
    b_done[3] = 0;
    check("b_ch3_immediate_idle", b_busy[3], 0);
    read_b(3'd3, 3'd4, 4'd0, "b_ch3_stall");
    read_b(3'd3, 3'd1, 4'd1, "b_ch3_done");
    read_b(3'd3, 3'd5, 4'd4, "b_ch3_last_lat");

    b_start[0] = 1; b_ready[0] = 1; step_b();
    b_start[0] = 0; b_ready[0] = 0; b_done[0] = 1; step_b();
    b_done[0] = 0;
    check("b_ch0_adj_idle", b_busy[0], 0);
    read_b(3'd0, 3'd5, 4'd2, "b_ch0_adj_lat");

    b_ready[2] = 1;
    for (int i = 0; i < 20; i++) step_b();
    b_ready[2] = 0;
    read_b(3'd2, 3'd2, 4'd15, "b_ready_sat");
    step_b();
    check("b_rd_hold", {b_rd_valid, b_rd_data}, {1'b0, 4'd15});

    b_rd_en = 1; b_rd_ch = 3'd5; b_rd_sel = 3'd0; step_b();
    check("b_oob", {b_rd_valid, b_rd_err, b_rd_data}, {2'b11, 4'd0});
    b_rd_en = 0; step_b();
    check("b_oob_after", {b_rd_valid, b_rd_err}, 2'b00);

    b_finish = 1; step_b(); b_finish = 0;
    check("b_frozen", b_frozen, 1);
    for (int i = 0; i < 5; i++) begin
      b_start[0] = 1; b_ready[0] = 1; step_b();
      b_start[0] = 0; b_ready[0] = 0; b_done[0] = 1; step_b();
      b_done[0] = 0;
      check("b_frozen_fsm", b_busy[0], 0);
    end
    read_b(3'd0, 3'd0, 4'd1, "b_frozen_start");
    read_b(3'd0, 3'd1, 4'd1, "b_frozen_done");
    read_b(3'd0, 3'd2, 4'd1, "b_frozen_ready");
    read_b(3'd0, 3'd3, 4'd1, "b_frozen_busy_cyc");
    b_clear = 1; step_b(); b_clear = 0;
    check("b_frozen_after_clear", b_frozen, 1);
    read_b(3'd2, 3'd2, 4'd0, "b_clear_ready");
    read_b(3'd0, 3'd0, 4'd0, "b_clear_start");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
